// File: rtl/pixy_bus_pkg.sv
// Shared definitions for the SRAM/peripheral bus arbiter: FSM state encoding,
// owner codes and the wait counter width.
package pixy_bus_pkg;

   localparam int WAIT_W = 4;

   localparam logic OWNER_CPU  = 1'b0;
   localparam logic OWNER_HOST = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACCESS  = 3'd1,
      ST_GATE    = 3'd2,
      ST_ACK     = 3'd3,
      ST_RELEASE = 3'd4
   } bus_state_e;

   // Request level of whichever side currently owns the bus.
   function automatic logic owner_request(input logic owner, input logic cpu_req,
                                          input logic host_req);
      return (owner == OWNER_HOST) ? host_req : cpu_req;
   endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state down-counter: loads on grant, counts down once per MCLK falling edge
// and flags zero so the arbiter knows the access window has elapsed.
module bus_wait_counter
   import pixy_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              dec,
   input  logic [WAIT_W-1:0] load_val,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Shares the SRAM/peripheral bus between the 68000 and the host loader, sequencing
// select, wait states, acknowledge and release; all state moves on the MCLK falling edge.
module bus_cycle_arbiter
   import pixy_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
)
(
   input  logic MCLK_IN,
   input  logic RUN_IN,
   input  logic CPU_REQ_IN,
   input  logic CPU_RW_IN,
   input  logic STEP_GRANT_IN,
   input  logic HOST_REQ_IN,
   input  logic HOST_RW_IN,
   output logic CPU_DTACK,
   output logic HOST_ACK,
   output logic OWNER,
   output logic MEM_CS,
   output logic MEM_OE,
   output logic MEM_WE
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

   bus_state_e state_q, state_d;
   logic owner_q, owner_d;
   logic rw_q, rw_d;
   logic last_owner_q, last_owner_d;
   logic cpu_dtack_q, cpu_dtack_d;
   logic host_ack_q, host_ack_d;
   logic mem_cs_q, mem_cs_d;
   logic mem_oe_q, mem_oe_d;
   logic mem_we_q, mem_we_d;

   logic cnt_load, cnt_dec, cnt_zero;
   logic grant_owner;
   logic own_req;

   bus_wait_counter u_wait_counter (
      .clk      (MCLK_IN),
      .rst_n    (RUN_IN),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (WAIT_LOAD),
      .zero     (cnt_zero)
   );

   assign own_req = owner_request(owner_q, CPU_REQ_IN, HOST_REQ_IN);

   always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWNER_CPU;
         rw_q         <= 1'b0;
         last_owner_q <= OWNER_HOST;
         cpu_dtack_q  <= 1'b0;
         host_ack_q   <= 1'b0;
         mem_cs_q     <= 1'b0;
         mem_oe_q     <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rw_q         <= rw_d;
         last_owner_q <= last_owner_d;
         cpu_dtack_q  <= cpu_dtack_d;
         host_ack_q   <= host_ack_d;
         mem_cs_q     <= mem_cs_d;
         mem_oe_q     <= mem_oe_d;
         mem_we_q     <= mem_we_d;
      end
   end

   // A tie goes to whoever did not own the previous cycle, so neither side starves.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rw_d         = rw_q;
      last_owner_d = last_owner_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      grant_owner  = OWNER_CPU;

      case (state_q)
         ST_IDLE: begin
            if (CPU_REQ_IN || HOST_REQ_IN) begin
               if (CPU_REQ_IN && HOST_REQ_IN) begin
                  grant_owner = ~last_owner_q;
               end else begin
                  grant_owner = HOST_REQ_IN ? OWNER_HOST : OWNER_CPU;
               end
               owner_d  = grant_owner;
               rw_d     = (grant_owner == OWNER_HOST) ? HOST_RW_IN : CPU_RW_IN;
               cnt_load = 1'b1;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!own_req) begin
               state_d = ST_RELEASE;
            end else if (cnt_zero) begin
               state_d = ((owner_q == OWNER_CPU) && !STEP_GRANT_IN) ? ST_GATE : ST_ACK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_GATE: begin
            if (!own_req) begin
               state_d = ST_RELEASE;
            end else if (STEP_GRANT_IN) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!own_req) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so strobes change cleanly on the edge.
   always_comb begin
      cpu_dtack_d = 1'b0;
      host_ack_d  = 1'b0;
      mem_cs_d    = 1'b0;
      mem_oe_d    = 1'b0;
      mem_we_d    = 1'b0;

      case (state_d)
         ST_ACCESS: begin
            mem_cs_d = 1'b1;
            mem_oe_d = rw_d;
            mem_we_d = ~rw_d;
         end
         ST_GATE: begin
            mem_cs_d = 1'b1;
            mem_oe_d = rw_d;
         end
         ST_ACK: begin
            mem_cs_d    = 1'b1;
            mem_oe_d    = rw_d;
            cpu_dtack_d = (owner_d == OWNER_CPU);
            host_ack_d  = (owner_d == OWNER_HOST);
         end
         default: begin
            mem_cs_d = 1'b0;
         end
      endcase
   end

   assign CPU_DTACK = cpu_dtack_q;
   assign HOST_ACK  = host_ack_q;
   assign OWNER     = owner_q;
   assign MEM_CS    = mem_cs_q;
   assign MEM_OE    = mem_oe_q;
   assign MEM_WE    = mem_we_q;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Scoreboard bench for bus_cycle_arbiter: a round-robin owner model queues the expected
// acknowledges, a posedge monitor checks each ack rise plus strobe rules, and directed
// sequences cover latency, step gating, contention, reset and abort.
module tb_bus_cycle_arbiter;
   import pixy_bus_pkg::*;

   localparam int WAIT_CYCLES = 2;

   logic MCLK_IN = 1'b0;
   logic RUN_IN = 1'b0;
   logic CPU_REQ_IN = 1'b0;
   logic CPU_RW_IN = 1'b0;
   logic STEP_GRANT_IN = 1'b1;
   logic HOST_REQ_IN = 1'b0;
   logic HOST_RW_IN = 1'b0;
   logic CPU_DTACK, HOST_ACK, OWNER, MEM_CS, MEM_OE, MEM_WE;

   bus_cycle_arbiter #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
      .MCLK_IN       (MCLK_IN),
      .RUN_IN        (RUN_IN),
      .CPU_REQ_IN    (CPU_REQ_IN),
      .CPU_RW_IN     (CPU_RW_IN),
      .STEP_GRANT_IN (STEP_GRANT_IN),
      .HOST_REQ_IN   (HOST_REQ_IN),
      .HOST_RW_IN    (HOST_RW_IN),
      .CPU_DTACK     (CPU_DTACK),
      .HOST_ACK      (HOST_ACK),
      .OWNER         (OWNER),
      .MEM_CS        (MEM_CS),
      .MEM_OE        (MEM_OE),
      .MEM_WE        (MEM_WE)
   );

   always #5 MCLK_IN = ~MCLK_IN;

   typedef struct packed {
      logic owner;
      logic rw;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int passes = 0;
   logic model_last = OWNER_HOST;
   logic prev_cpu_ack = 1'b0;
   logic prev_host_ack = 1'b0;
   logic grant_at_edge = 1'b1;

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual == required) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
      end
   endtask

   task automatic nextEdge();
      @(posedge MCLK_IN);
   endtask

   function automatic void pushCycle(input logic owner, input logic rw);
      exp_t e;
      e.owner = owner;
      e.rw    = rw;
      exp_q.push_back(e);
   endfunction

   function automatic int allOutputs();
      return int'({CPU_DTACK, HOST_ACK, OWNER, MEM_CS, MEM_OE, MEM_WE});
   endfunction

   // Step grant as the arbiter saw it on the active edge.
   always @(negedge MCLK_IN) grant_at_edge = STEP_GRANT_IN;

   // Monitor: every acknowledge rise must match the next queued transfer.
   always @(posedge MCLK_IN) begin
      exp_t e;
      if (RUN_IN) begin
         if (MEM_WE) begin
            checkOutput("we_without_cs", int'(MEM_CS), 1);
            checkOutput("we_with_oe", int'(MEM_OE), 0);
         end
         if (CPU_DTACK || HOST_ACK) begin
            checkOutput("we_during_ack", int'(MEM_WE), 0);
         end
         if ((CPU_DTACK && !prev_cpu_ack) || (HOST_ACK && !prev_host_ack)) begin
            if (exp_q.size() == 0) begin
               checkOutput("ack_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("ack_owner", int'({CPU_DTACK, HOST_ACK}),
                           (e.owner == OWNER_HOST) ? 1 : 2);
               checkOutput("owner_out", int'(OWNER), int'(e.owner));
               checkOutput("ack_oe", int'(MEM_OE), int'(e.rw));
               checkOutput("ack_cs", int'(MEM_CS), 1);
               if (CPU_DTACK) checkOutput("dtack_step_grant", int'(grant_at_edge), 1);
            end
         end
      end
      prev_cpu_ack  = CPU_DTACK;
      prev_host_ack = HOST_ACK;
   end

   task automatic applyReset();
      @(posedge MCLK_IN);
      #2 RUN_IN = 1'b0;
      CPU_REQ_IN    = 1'b0;
      HOST_REQ_IN   = 1'b0;
      STEP_GRANT_IN = 1'b1;
      #1 checkOutput("reset_outputs", allOutputs(), 0);
      @(posedge MCLK_IN);
      RUN_IN = 1'b1;
      model_last = OWNER_HOST;
   endtask

   // One contention round: hold each request until its ack, model the round-robin order.
   task automatic applyStimulus(input logic cpu_on, input logic host_on, input logic cpu_rw,
                                input logic host_rw, input int step_low);
      logic first;
      if (cpu_on && host_on) begin
         first = ~model_last;
         pushCycle(first, (first == OWNER_HOST) ? host_rw : cpu_rw);
         pushCycle(~first, (first == OWNER_HOST) ? cpu_rw : host_rw);
         model_last = ~first;
      end else if (cpu_on) begin
         pushCycle(OWNER_CPU, cpu_rw);
         model_last = OWNER_CPU;
      end else begin
         pushCycle(OWNER_HOST, host_rw);
         model_last = OWNER_HOST;
      end
      STEP_GRANT_IN = (step_low == 0);
      CPU_RW_IN     = cpu_rw;
      HOST_RW_IN    = host_rw;
      CPU_REQ_IN    = cpu_on;
      HOST_REQ_IN   = host_on;
      for (int n = 0; n < 200 && (CPU_REQ_IN || HOST_REQ_IN); n++) begin
         nextEdge();
         if (n + 1 >= step_low) STEP_GRANT_IN = 1'b1;
         if (CPU_DTACK) CPU_REQ_IN = 1'b0;
         if (HOST_ACK) HOST_REQ_IN = 1'b0;
      end
      if (CPU_REQ_IN || HOST_REQ_IN) begin
         checkOutput("round_timeout", 1, 0);
         CPU_REQ_IN  = 1'b0;
         HOST_REQ_IN = 1'b0;
      end
      STEP_GRANT_IN = 1'b1;
      repeat (3) nextEdge();
   endtask

   task automatic waitAck(input string name, input logic host);
      int n;
      n = 0;
      while (((host ? HOST_ACK : CPU_DTACK) == 1'b0) && n < 50) begin
         nextEdge();
         n++;
      end
      checkOutput(name, int'(host ? HOST_ACK : CPU_DTACK), 1);
   endtask

   initial begin
      int n;
      logic c_on, h_on;

      // Reset state
      #12 checkOutput("reset_outputs", allOutputs(), 0);
      @(posedge MCLK_IN);
      RUN_IN = 1'b1;
      nextEdge();
      checkOutput("idle_outputs", allOutputs(), 0);

      // CPU read latency: CS/OE at grant edge, DTACK WAIT_CYCLES+1 edges later
      CPU_RW_IN  = 1'b1;
      CPU_REQ_IN = 1'b1;
      pushCycle(OWNER_CPU, 1'b1);
      model_last = OWNER_CPU;
      nextEdge();
      checkOutput("rd_grant_cs_oe_we", int'({MEM_CS, MEM_OE, MEM_WE, OWNER}), 4'b1100);
      for (int i = 0; i < WAIT_CYCLES; i++) begin
         nextEdge();
         checkOutput("rd_dtack_early", int'(CPU_DTACK), 0);
      end
      nextEdge();
      checkOutput("rd_dtack_latency", int'(CPU_DTACK), 1);
      CPU_REQ_IN = 1'b0;
      nextEdge();
      checkOutput("rd_release_outputs", int'({CPU_DTACK, HOST_ACK, MEM_CS, MEM_OE, MEM_WE}), 0);
      nextEdge();
      checkOutput("rd_idle_outputs", int'({CPU_DTACK, HOST_ACK, MEM_CS, MEM_OE, MEM_WE}), 0);
      nextEdge();

      // CPU write stalled by the stepper
      STEP_GRANT_IN = 1'b0;
      CPU_RW_IN     = 1'b0;
      CPU_REQ_IN    = 1'b1;
      pushCycle(OWNER_CPU, 1'b0);
      model_last = OWNER_CPU;
      nextEdge();
      checkOutput("wr_access_we_oe", int'({MEM_WE, MEM_OE}), 2'b10);
      for (int i = 0; i < WAIT_CYCLES; i++) nextEdge();
      checkOutput("wr_last_access_we", int'(MEM_WE), 1);
      nextEdge();
      checkOutput("gate_cs_we_dtack", int'({MEM_CS, MEM_WE, CPU_DTACK}), 3'b100);
      repeat (9) nextEdge();
      checkOutput("gate_hold_dtack", int'({MEM_CS, CPU_DTACK}), 2'b10);
      STEP_GRANT_IN = 1'b1;
      nextEdge();
      checkOutput("gate_release_dtack", int'(CPU_DTACK), 1);
      CPU_REQ_IN = 1'b0;
      repeat (3) nextEdge();

      // Ties after reset: CPU, host, CPU, host
      applyReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0);

      // Host write in flight, CPU waits
      HOST_RW_IN  = 1'b0;
      HOST_REQ_IN = 1'b1;
      pushCycle(OWNER_HOST, 1'b0);
      nextEdge();
      CPU_RW_IN  = 1'b1;
      CPU_REQ_IN = 1'b1;
      pushCycle(OWNER_CPU, 1'b1);
      waitAck("host_ack_seen", 1'b1);
      checkOutput("host_owner_hold", int'({OWNER, CPU_DTACK}), 2'b10);
      HOST_REQ_IN = 1'b0;
      n = 0;
      while (!(MEM_CS && OWNER == OWNER_CPU) && n < 10) begin
         nextEdge();
         n++;
      end
      // Drop seen on the first edge, RELEASE on the second, CPU granted on the third.
      checkOutput("cpu_grant_gap", n, 3);
      waitAck("cpu_ack_after_host", 1'b0);
      CPU_REQ_IN = 1'b0;
      model_last = OWNER_CPU;
      repeat (3) nextEdge();

      // Reset mid-ACCESS, then a normal grant
      CPU_RW_IN  = 1'b1;
      CPU_REQ_IN = 1'b1;
      nextEdge();
      checkOutput("pre_reset_cs", int'(MEM_CS), 1);
      applyReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0);

      // Reset mid-ACK
      HOST_RW_IN  = 1'b1;
      HOST_REQ_IN = 1'b1;
      pushCycle(OWNER_HOST, 1'b1);
      waitAck("host_ack_before_reset", 1'b1);
      applyReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2);

      // Abort: CPU drops in ACCESS while the host waits
      CPU_RW_IN  = 1'b1;
      CPU_REQ_IN = 1'b1;
      nextEdge();
      CPU_REQ_IN  = 1'b0;
      HOST_RW_IN  = 1'b1;
      HOST_REQ_IN = 1'b1;
      pushCycle(OWNER_HOST, 1'b1);
      nextEdge();
      checkOutput("abort_release", int'({MEM_CS, MEM_OE, CPU_DTACK}), 0);
      nextEdge();
      checkOutput("abort_idle", int'(MEM_CS), 0);
      nextEdge();
      checkOutput("abort_host_grant", int'({MEM_CS, OWNER}), 2'b11);
      waitAck("abort_host_ack", 1'b1);
      HOST_REQ_IN = 1'b0;
      model_last = OWNER_HOST;
      repeat (3) nextEdge();

      // Random contention rounds
      for (int r = 0; r < 30; r++) begin
         c_on = 1'($urandom_range(0, 1));
         h_on = c_on ? 1'($urandom_range(0, 1)) : 1'b1;
         applyStimulus(c_on, h_on, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 6)));
      end

      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
